popcount_binarize_pack: RTL
===========================

# popcount_binarize_pack

Downstream stage of the XNOR-popcount unit in the binary-NN datapath. Accumulates per-word popcounts over the NWORDS input words of one neuron. Converts the total to a signed dot product and compares it against a per-neuron threshold to produce a 1-bit activation. Packs NOUT consecutive activations LSB-first into one word for the next layer's XNOR-popcount input.

## Interface
- WL, 112, bits per popcount word (popcount range 0..WL)
- NWORDS, 4, popcount words per neuron (>=1)
- NOUT, 112, activations per packed output word (>=2)
- ACCW, 16, signed accumulator/threshold width; must hold ±NWORDS*WL
- iCLK  in  1  clock, all logic on rising edge
- iRST  in  1  one clock; reset is synchronous and active-high
- iEN  in  1  popcount valid strobe (from popcount oEN)
- idata  in  11  unsigned popcount of one word, 0..WL
- iTHRESH  in  ACCW  signed threshold, sampled on the neuron's last-word cycle
- iFLUSH  in  1  force out partially filled packed word
- oACT  out  1  activation bit of the last completed neuron
- oACT_EN  out  1  one-cycle strobe, oACT valid
- odata  out  NOUT  packed activations, bit k = k-th neuron of the word
- oEN  out  1  one-cycle strobe, odata valid

## Operation
- FSM states:
  - S_IDLE: word_cnt=0, acc=0.
  - S_ACC: neuron partially accumulated.
- S_IDLE→S_ACC on iEN when NWORDS>1.
- S_ACC→S_IDLE on the iEN cycle with word_cnt==NWORDS-1.
- No iEN: hold state. Gaps between strobes are legal.
- Each iEN: acc += idata (zero-extended), word_cnt++.
- Last word: sum = acc+idata, dot = 2*sum − NWORDS*WL (signed, ACCW bits), act = (dot >= iTHRESH). Then acc and word_cnt clear.
- Packer: on each completed neuron, act is written to pack[neu_cnt] and neu_cnt++.
  - If neu_cnt reaches NOUT, odata ← pack with the new bit, oEN pulses, then pack and neu_cnt clear.
  - Bits beyond neu_cnt in pack are always 0.
- iFLUSH:
  - Discards any partial neuron (acc, word_cnt cleared, FSM→S_IDLE).
  - If neu_cnt>0: odata ← pack (unfilled bits 0), oEN pulses, pack and neu_cnt clear.
  - If neu_cnt==0: no oEN.
- iFLUSH with iEN on the same cycle: iEN processed first. If it completes a neuron, that bit is included in the flushed word. If it completes the NOUT-th bit, a single oEN is issued. A non-completing iEN word is discarded by the flush.
- idata > WL: out of contract, no checking required.

## Timing
- Reset values: oACT=0, oACT_EN=0, odata=0, oEN=0. Reset also clears acc=0, word_cnt=0, neu_cnt=0, pack=0, FSM=S_IDLE.
- iRST overrides iEN/iFLUSH on the same cycle. Reset mid-neuron or mid-pack drops all partial data.
- Activation latency:
  - The last-word iEN sampled at edge N gives oACT/oACT_EN valid after edge N, for one cycle.
  - oACT holds its value until the next completion; oACT_EN is high one cycle only.
- Pack latency:
  - oEN is asserted in the same cycle as the oACT_EN of the NOUT-th neuron.
  - Flush-triggered oEN comes one cycle after the iFLUSH edge.
- odata holds until the next oEN.
- Throughput: one iEN per cycle sustained, with no stall or backpressure.

## Test plan
- NWORDS=4, WL=112, iTHRESH=0; popcounts 112,112,112,112 → dot=448, oACT=1 with oACT_EN one cycle after the 4th iEN; popcounts 0,0,0,0 → dot=−448, oACT=0.
- Popcounts 56×4 (dot=0): iTHRESH=0 → oACT=1; iTHRESH=1 → oACT=0; iTHRESH=−448 with popcounts 0×4 → oACT=1.
- 112 neurons with activations alternating 1,0,… (neuron 0 = 1), iEN back-to-back and with random gaps → exactly one oEN, odata=112'h5555…5555, coincident with the 112th oACT_EN.
- 3 neurons with activations 1,1,0, then 2 words of a 4th neuron, then iFLUSH → odata=112'h3, oEN one cycle later. A following 4-word neuron is evaluated from a fresh accumulator.
- Reset after 2 words of 112 and 5 packed bits; then 4 words of 112 → oACT=1 only after the 4th post-reset word, and the packer restarts at bit 0. All outputs read 0 in the cycle after reset.
- iFLUSH coincident with the 112th neuron's last iEN → single oEN with full 112-bit word; the next word starts empty.

Source files
------------

// File: rtl/popcount_binarize_pack.sv
// Accumulates per-word popcounts into a neuron dot product, thresholds it to a
// 1-bit activation, and packs NOUT activations LSB-first into an output word.
module popcount_binarize_pack #(
  parameter int WL     = 112,
  parameter int NWORDS = 4,
  parameter int NOUT   = 112,
  parameter int ACCW   = 16
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic                   iEN,
  input  logic [10:0]            idata,
  input  logic signed [ACCW-1:0] iTHRESH,
  input  logic                   iFLUSH,
  output logic                   oACT,
  output logic                   oACT_EN,
  output logic [NOUT-1:0]        odata,
  output logic                   oEN
);

  localparam int WCW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int NCW = $clog2(NOUT + 1);

  typedef enum logic {S_IDLE, S_ACC} state_t;

  state_t           state;
  logic [ACCW-1:0]  acc;
  logic [WCW-1:0]   word_cnt;
  logic [NCW-1:0]   neu_cnt;
  logic [NOUT-1:0]  pack;

  logic                   last;
  logic [ACCW-1:0]        sum;
  logic signed [ACCW-1:0] dot;
  logic                   act;
  logic [NOUT-1:0]        pack_nxt;
  logic [NCW-1:0]         neu_nxt;
  logic                   emit;

  always_comb begin
    last     = iEN && ((NWORDS == 1) ||
                       (state == S_ACC && word_cnt == WCW'(NWORDS - 1)));
    sum      = acc + ACCW'(idata);
    dot      = $signed((sum << 1) - ACCW'(NWORDS * WL));
    act      = (dot >= iTHRESH);
    pack_nxt = pack;
    neu_nxt  = neu_cnt;
    if (last) begin
      pack_nxt[neu_cnt] = act;
      neu_nxt           = neu_cnt + NCW'(1);
    end
    // A completing iEN is folded in before the flush decision, so a flush on
    // the NOUT-th completion still yields a single full-word emit.
    emit = (neu_nxt == NCW'(NOUT)) || (iFLUSH && neu_nxt != '0);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= S_IDLE;
      acc      <= '0;
      word_cnt <= '0;
      neu_cnt  <= '0;
      pack     <= '0;
      oACT     <= 1'b0;
      oACT_EN  <= 1'b0;
      odata    <= '0;
      oEN      <= 1'b0;
    end else begin
      oACT_EN <= 1'b0;
      oEN     <= 1'b0;

      if (last) begin
        oACT    <= act;
        oACT_EN <= 1'b1;
      end

      if (emit) begin
        odata   <= pack_nxt;
        oEN     <= 1'b1;
        pack    <= '0;
        neu_cnt <= '0;
      end else begin
        pack    <= pack_nxt;
        neu_cnt <= neu_nxt;
      end

      if (last || iFLUSH) begin
        state    <= S_IDLE;
        acc      <= '0;
        word_cnt <= '0;
      end else if (iEN) begin
        state    <= S_ACC;
        acc      <= sum;
        word_cnt <= word_cnt + WCW'(1);
      end
    end
  end

endmodule
